// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg
//   Shared constants for the switch debouncer: the default qualification
//   length and the FSM state encodings. Imported by switch_debounce.
package switch_debounce_pkg;

  // 10 ms at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // State bit 1 equals the debounced level held in that state.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b11,
    WAIT_LO = 2'b10
  } db_state_e;

endpackage

// File: rtl/switch_debounce_sync_ff.sv
// sync_ff
//   Plain SYNC_STAGES-deep flop chain for bringing an asynchronous board
//   input into the clk domain. No logic between stages.
// Ports:
//   clk   - sampling clock (rising edge)
//   rst_n - asynchronous active-low reset, clears the whole chain to 0
//   d     - asynchronous input
//   q     - synchronised output (last stage)
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce
//   Conditions a raw switch/pushbutton pin: synchronises it, rejects contact
//   bounce with a stability counter, and presents a clean registered level
//   plus single-cycle rise/fall pulses.
// Configuration macro:
//   SWITCH_DEBOUNCE_TOGGLE_EN - when defined, tgl_out is a registered level
//   that inverts after every rise_pulse; otherwise tgl_out is constant 0.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   sw_in      - raw asynchronous bouncing switch level
//   sw_out     - debounced registered level
//   rise_pulse - one cycle high when sw_out goes 0->1
//   fall_pulse - one cycle high when sw_out goes 1->0
//   busy       - high while a candidate transition is being qualified
//   tgl_out    - toggle level (see macro above)
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy,
  output logic tgl_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sw_in),
    .q    (s)
  );

  // The sample that starts a candidate counts as the first of the run,
  // hence the load of 1 on entry to a WAIT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_LO;
      cnt        <= '0;
      sw_out     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      unique case (state)
        IDLE_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= IDLE_HI;
            sw_out     <= 1'b1;
            rise_pulse <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= IDLE_LO;
            sw_out     <= 1'b0;
            fall_pulse <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT_HI) || (state == WAIT_LO);

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic tgl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_q <= 1'b0;
    end else begin
      tgl_q <= tgl_q ^ rise_pulse;
    end
  end

  assign tgl_out = tgl_q;
`else
  assign tgl_out = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce
//   Self-checking bench for switch_debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
//   Reference model: s is sw_in delayed by SYNC_STAGES samples; the output
//   flips once s has differed from it for DEBOUNCE_CYCLES consecutive samples.
module tb_switch_debounce;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;

  logic clk;
  logic rst_n;
  logic sw_in;
  logic sw_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;
  logic tgl_out;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // reference model state
  logic        pipe[$];
  logic        out_m;
  int unsigned run_m;
  logic        rp_m;
  logic        fp_m;
  logic        tgl_m;

  // directed-phase observation counters
  int unsigned rise_seen;
  int unsigned fall_seen;
  int unsigned busy_seen;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .sw_out    (sw_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy),
    .tgl_out   (tgl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int unsigned i = 0; i < SYNC; i++) pipe.push_back(1'b0);
    out_m = 1'b0;
    run_m = 0;
    rp_m  = 1'b0;
    fp_m  = 1'b0;
    tgl_m = 1'b0;
  endtask

  function automatic logic tgl_expected();
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    return tgl_m;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: advance the model on the edge, compare all outputs 1 ns later.
  task automatic step();
    logic s;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      tgl_m = tgl_m ^ rp_m;
      pipe.push_back(sw_in);
      s    = pipe.pop_front();
      rp_m = 1'b0;
      fp_m = 1'b0;
      if (s != out_m) begin
        run_m++;
        if (run_m == DEB) begin
          out_m = s;
          rp_m  = s;
          fp_m  = !s;
          run_m = 0;
        end
      end else begin
        run_m = 0;
      end
    end
    #1;
    chk("sw_out", sw_out, out_m);
    chk("rise_pulse", rise_pulse, rp_m);
    chk("fall_pulse", fall_pulse, fp_m);
    chk("busy", busy, run_m != 0);
    chk("tgl_out", tgl_out, tgl_expected());
    chk("pulse_excl", rise_pulse & fall_pulse, 1'b0);
    rise_seen += int'(rise_pulse);
    fall_seen += int'(fall_pulse);
    busy_seen += int'(busy);
  endtask

  task automatic clear_seen();
    rise_seen = 0;
    fall_seen = 0;
    busy_seen = 0;
  endtask

  task automatic hold(input logic v, input int unsigned n);
    sw_in = v;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = 1'b1;
    model_reset();
    clear_seen();

    // reset held with switch high: everything stays 0
    hold(1'b1, 3);
    chk("rst_sw_out", sw_out, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // power-up with switch held: one rise after SYNC+DEB edges
    rst_n = 1'b1;
    clear_seen();
    hold(1'b1, SYNC + DEB - 1);
    chk("pwr_not_yet", sw_out, 1'b0);
    hold(1'b1, 1);
    chk("pwr_sw_out", sw_out, 1'b1);
    chk("pwr_rise", rise_pulse, 1'b1);
    hold(1'b1, 8);
    chk_int("pwr_rise_count", rise_seen, 1);

    // release, then clean press: busy for DEB-1 cycles, one rise
    hold(1'b0, 10);
    clear_seen();
    hold(1'b1, SYNC + DEB + 4);
    chk_int("press_busy_cycles", busy_seen, DEB - 1);
    chk_int("press_rise_count", rise_seen, 1);

    // glitch low for 3 cycles while high: no fall, stays high
    clear_seen();
    hold(1'b0, DEB - 1);
    hold(1'b1, 10);
    chk_int("glitch_fall_count", fall_seen, 0);
    chk("glitch_sw_out", sw_out, 1'b1);

    // bounce-back on the final sample: low for exactly DEB-1 synchronised samples
    clear_seen();
    hold(1'b0, DEB - 1);
    hold(1'b1, 10);
    chk_int("lastcyc_fall_count", fall_seen, 0);

    // release, then bouncing press settling high
    hold(1'b0, 10);
    clear_seen();
    for (int unsigned k = 0; k < 2; k++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    chk_int("bounce_rise_during", rise_seen, 0);
    hold(1'b1, SYNC + DEB + 3);
    chk_int("bounce_rise_count", rise_seen, 1);

    // reset mid-qualification: release switch, abort with async reset
    hold(1'b0, SYNC + 1);
    chk("midq_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midq_async_sw_out", sw_out, 1'b0);
    chk("midq_async_busy", busy, 1'b0);
    hold(1'b0, 2);
    rst_n = 1'b1;
    clear_seen();
    hold(1'b0, 12);
    chk_int("midq_no_pulse", rise_seen + fall_seen, 0);

    // three clean presses exercise the toggle level
    for (int unsigned k = 0; k < 3; k++) begin
      hold(1'b1, SYNC + DEB + 3);
      hold(1'b0, SYNC + DEB + 3);
    end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
    chk("toggle_after_3", tgl_out, 1'b1);
`else
    chk("toggle_disabled", tgl_out, 1'b0);
`endif

    // randomized bouncing runs checked cycle-by-cycle against the model
    for (int unsigned k = 0; k < 400; k++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
